rename_stage: RTL

Register-rename stage directly downstream of the frontend's decode skid buffer. It consumes one decoded instruction per cycle over a valid/ready handshake and maps architectural sources through a register alias table (RAT). It allocates a physical destination from a circular free list and presents the renamed instruction to dispatch through a one-entry output register. Commit returns retired physical registers through a free port.

---
 rtl/rename_stage_if.sv | 47 ++++
 rtl/rename_stage.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/rename_stage_if.sv
// rename_stage_if
//   Bundles the signals between the rename stage and its neighbours.
//   - Decode side: valid_in / ready_out handshake with pc_in, rs1_in, rs2_in, rd_in and has_rd_in.
//   - Dispatch side: valid_out / ready_in handshake with pc_out, prs1_out, prs2_out, prd_out,
//     old_prd_out and has_rd_out.
//   - Commit free port: free_valid and free_preg, plus the free_count status output.
//   Modports:
//   - slave: the rename stage itself.
//   - master: whatever drives the stage (decode, dispatch and commit models).
interface rename_stage_if #(
    parameter int PR_W = 7
);
    logic            valid_in;
    logic            ready_out;
    logic [31:0]     pc_in;
    logic [4:0]      rs1_in;
    logic [4:0]      rs2_in;
    logic [4:0]      rd_in;
    logic            has_rd_in;

    logic            valid_out;
    logic            ready_in;
    logic [31:0]     pc_out;
    logic [PR_W-1:0] prs1_out;
    logic [PR_W-1:0] prs2_out;
    logic [PR_W-1:0] prd_out;
    logic [PR_W-1:0] old_prd_out;
    logic            has_rd_out;

    logic            free_valid;
    logic [PR_W-1:0] free_preg;
    logic [PR_W:0]   free_count;

    modport slave (
        input  valid_in, pc_in, rs1_in, rs2_in, rd_in, has_rd_in,
        input  ready_in, free_valid, free_preg,
        output ready_out, valid_out, pc_out, prs1_out, prs2_out,
        output prd_out, old_prd_out, has_rd_out, free_count
    );

    modport master (
        output valid_in, pc_in, rs1_in, rs2_in, rd_in, has_rd_in,
        output ready_in, free_valid, free_preg,
        input  ready_out, valid_out, pc_out, prs1_out, prs2_out,
        input  prd_out, old_prd_out, has_rd_out, free_count
    );
endinterface

// File: rtl/rename_stage.sv
// rename_stage
//   Register-rename stage. It accepts one decoded instruction per cycle and maps its sources
//   through the register alias table (RAT). When the instruction writes a non-zero rd, it takes
//   a physical destination from a circular free list. The renamed instruction is held in a
//   one-entry output register for dispatch. Commit hands retired physical registers back
//   through the free port.
//
//   Ports:
//   - clk, reset: clock and synchronous active-high reset.
//   - rn (rename_stage_if.slave): decode handshake, dispatch handshake, free port and free_count.
//   - stall_cnt (present only with RENAME_STATS_EN): counts the cycles stalled purely because
//     the free list is empty. It saturates at all-ones.
//
//   Optional feature macro: RENAME_STATS_EN.
module rename_stage #(
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 128,
    parameter int PR_W      = $clog2(PHYS_REGS)
) (
    input  logic          clk,
    input  logic          reset,
    rename_stage_if.slave rn
`ifdef RENAME_STATS_EN
    ,
    output logic [31:0]   stall_cnt
`endif
);
    localparam int FL_DEPTH = PHYS_REGS - ARCH_REGS;
    localparam int FL_W     = $clog2(FL_DEPTH);

    logic [PR_W-1:0] rat_q [ARCH_REGS];
    logic [PR_W-1:0] fl_q  [FL_DEPTH];
    logic [FL_W-1:0] head_q, head_d;
    logic [FL_W-1:0] tail_q, tail_d;
    logic [PR_W:0]   count_q, count_d;

    logic            valid_q;
    logic [31:0]     pc_q;
    logic [PR_W-1:0] prs1_q, prs2_q, prd_q, old_prd_q;
    logic            has_rd_q;

    logic            need_rd;
    logic            fl_empty;
    logic            ready;
    logic            fire;
    logic            alloc;
    logic            free_en;
    logic [PR_W-1:0] alloc_preg;

    // The empty test uses the registered count, so a register freed this cycle
    // only becomes allocatable on the next cycle.
    assign need_rd    = rn.has_rd_in && (rn.rd_in != 5'd0);
    assign fl_empty   = (count_q == '0);
    assign ready      = (!valid_q || rn.ready_in) && (!need_rd || !fl_empty);
    assign fire       = rn.valid_in && ready;
    assign alloc      = fire && need_rd;
    assign free_en    = rn.free_valid && (rn.free_preg != '0) &&
                        (count_q < (PR_W+1)'(FL_DEPTH));
    assign alloc_preg = fl_q[head_q];

    // Depth is not a power of two, so the pointers wrap by explicit compare.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (alloc) begin
            head_d = (head_q == FL_W'(FL_DEPTH - 1)) ? '0 : head_q + 1'b1;
        end
        if (free_en) begin
            tail_d = (tail_q == FL_W'(FL_DEPTH - 1)) ? '0 : tail_q + 1'b1;
        end
        count_d = count_q + (PR_W+1)'(free_en) - (PR_W+1)'(alloc);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= (PR_W+1)'(FL_DEPTH);
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // RAT and free-list storage. Reset restores the identity map and p32..p127 in order.
    // x0 is never written because alloc requires rd_in != 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                rat_q[i] <= PR_W'(i);
            end
            for (int i = 0; i < FL_DEPTH; i++) begin
                fl_q[i] <= PR_W'(ARCH_REGS + i);
            end
        end else begin
            if (alloc) begin
                rat_q[rn.rd_in] <= alloc_preg;
            end
            if (free_en) begin
                fl_q[tail_q] <= rn.free_preg;
            end
        end
    end

    // Output register. Sources read the RAT before this edge's update, so rs == rd
    // sees the previous mapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            prs1_q    <= '0;
            prs2_q    <= '0;
            prd_q     <= '0;
            old_prd_q <= '0;
            has_rd_q  <= 1'b0;
        end else if (fire) begin
            valid_q   <= 1'b1;
            pc_q      <= rn.pc_in;
            prs1_q    <= rat_q[rn.rs1_in];
            prs2_q    <= rat_q[rn.rs2_in];
            prd_q     <= need_rd ? alloc_preg : '0;
            old_prd_q <= need_rd ? rat_q[rn.rd_in] : '0;
            has_rd_q  <= need_rd;
        end else if (rn.ready_in) begin
            valid_q   <= 1'b0;
        end
    end

    assign rn.ready_out   = ready;
    assign rn.valid_out   = valid_q;
    assign rn.pc_out      = pc_q;
    assign rn.prs1_out    = prs1_q;
    assign rn.prs2_out    = prs2_q;
    assign rn.prd_out     = prd_q;
    assign rn.old_prd_out = old_prd_q;
    assign rn.has_rd_out  = has_rd_q;
    assign rn.free_count  = count_q;

`ifdef RENAME_STATS_EN
    logic [31:0] stall_cnt_q;
    logic        stall_empty;

    // The output register could take the instruction; only the empty free list blocks it.
    assign stall_empty = rn.valid_in && need_rd && fl_empty && (!valid_q || rn.ready_in);

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (stall_empty && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif
endmodule
